ifid_stage_buf: RTL and testbench
=================================

# ifid_stage_buf

Parametrised IF/ID pipeline stage between instruction fetch and instruction decode. It replaces the plain stall-and-hold register with a valid/ready front end backed by a 2-entry skid buffer, so fetch may issue in the cycle a decode stall is raised without losing an instruction. A flush input squashes everything in flight and presents the NOP encoding to decode. An optional saturating bubble counter is available for performance measurement.

## Interface
Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, program counter width in bits.
- NOP, 32'hF0000000, instruction word presented when the output is invalid. Width INSTR_W.
- CNT_W, 16, bubble counter width. Used only with IFID_BUBBLE_CNT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- instr_in  in  INSTR_W  fetched instruction.
- pc_in  in  PC_W  PC of the fetched instruction.
- stall  in  1  decode data hazard; decode does not consume instr_out this cycle.
- flush  in  1  PC hazard (taken branch/jump); squash all held instructions.
- out_valid  out  1  instr_out/pc_out hold a real instruction.
- instr_out  out  INSTR_W  instruction to decode; equals NOP whenever out_valid=0.
- pc_out  out  PC_W  PC of instr_out.
- bubble_cnt  out  CNT_W  bubble cycles seen; present only with IFID_BUBBLE_CNT_EN.

## Operation
- State: output entry (out_valid, instr_out, pc_out) and skid entry (skid_valid, skid_instr, skid_pc). Occupancy is 0, 1 or 2.
- in_ready = !skid_valid. It is driven directly from a flop, with no combinational path from stall, flush or in_valid.
- accept = in_valid && in_ready.
- Each cycle, the first matching rule applies:
  1. rst: out_valid=0, instr_out=NOP, pc_out=0, skid_valid=0; skid data is don't-care.
  2. flush: out_valid=0, instr_out=NOP, pc_out held, skid_valid=0. Any accept this cycle is discarded. Flush overrides stall.
  3. !stall && skid_valid: the skid entry moves to the output and skid_valid=0. No accept is possible, since in_ready=0.
  4. !stall && !skid_valid: if accept, the output loads the input (out_valid=1). Otherwise out_valid=0, instr_out=NOP, pc_out held.
  5. stall && !out_valid: if accept, the output loads the input. An empty output entry is filled even under stall.
  6. stall && out_valid: the output is held. If accept, the skid entry loads the input and skid_valid=1.
- Ordering is strictly FIFO. An instruction is never duplicated and never dropped, except by flush.
- pc_out is never changed by a bubble. It keeps the last real PC for debug.

## Timing
- Latency from input to output is 1 cycle when the stage is empty and stall=0.
- Throughput is 1 instruction/cycle when stall=0 and the skid entry is empty.
- After a stall releases with the skid entry full, in_ready stays 0 for one cycle while the skid entry drains. in_ready returns to 1 on the following cycle.
- After flush, the next cycle has out_valid=0 and in_ready=1. A new instruction accepted in that cycle appears on the output one cycle later.
- Reset values: out_valid=0, instr_out=NOP, pc_out=0, in_ready=1, bubble_cnt=0.
- If rst is asserted mid-operation, all held instructions are lost and the reset values apply from the next edge.
- stall and flush are sampled only at the clock edge. Both asserted together behaves as flush alone.

## Configuration
- IFID_BUBBLE_CNT_EN is defined: bubble_cnt is present.
  - It increments by 1 on every edge where rst=0 and the registered out_valid=0, i.e. each cycle decode sees NOP.
  - It saturates at 2^CNT_W-1 and clears only on rst.
- IFID_BUBBLE_CNT_EN is undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then stream 4 instructions with PCs 0x0, 0x4, 0x8, 0xC at in_valid=1 and stall=0 → out_valid rises one cycle later; the outputs match in order, one per cycle; in_ready stays 1.
- With 0x4 at the output, assert stall for 3 cycles while fetch offers 0x8 then 0xC → 0x8 is captured in the skid entry; in_ready=0 on the next cycle and 0xC is not accepted. After release, the outputs are 0x4, 0x8, 0xC with no loss or duplication.
- With both entries full, assert flush and stall together with in_valid=1 → next cycle out_valid=0, instr_out=32'hF0000000, in_ready=1, pc_out unchanged. The offered instruction never appears at the output.
- Assert rst with 2 entries held → out_valid=0, pc_out=0, in_ready=1 on the next edge. After release, the next accepted instruction is output normally.
- In a build with IFID_BUBBLE_CNT_EN and CNT_W=4, leave in_valid=0 for 20 cycles after reset → bubble_cnt counts 1..15 and holds at 15; rst returns it to 0.

Source files
------------

// File: rtl/ifid_stage_buf.sv
// IF/ID pipeline stage with valid/ready input, 2-entry skid buffer and flush-to-NOP.
// Define IFID_BUBBLE_CNT_EN to add the saturating bubble_cnt performance counter.
module ifid_stage_buf #(
    parameter int unsigned          INSTR_W = 32,
    parameter int unsigned          PC_W    = 32,
    parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(32'hF000_0000),
    parameter int unsigned          CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out
`ifdef IFID_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               ready_q, ready_d;
    logic               accept;

    assign accept = in_valid && ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            instr_d      = NOP;
            skid_valid_d = 1'b0;
        end else if (!stall && skid_valid_q) begin
            out_valid_d  = 1'b1;
            instr_d      = skid_instr_q;
            pc_d         = skid_pc_q;
            skid_valid_d = 1'b0;
        end else if (!stall) begin
            if (accept) begin
                out_valid_d = 1'b1;
                instr_d     = instr_in;
                pc_d        = pc_in;
            end else begin
                // Bubble: pc_out keeps the last real PC for debug.
                out_valid_d = 1'b0;
                instr_d     = NOP;
            end
        end else if (!out_valid_q) begin
            if (accept) begin
                out_valid_d = 1'b1;
                instr_d     = instr_in;
                pc_d        = pc_in;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = instr_in;
            skid_pc_d    = pc_in;
        end

        // Registered so in_ready has no combinational path from stall/flush/in_valid.
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            instr_q      <= NOP;
            pc_q         <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    // Skid payload is only meaningful while skid_valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_q;

`ifdef IFID_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!out_valid_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ifid_stage_buf.sv
// Bench for ifid_stage_buf: queue-based reference model checked every cycle, plus literal pins.
module tb_ifid_stage_buf;

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOPW  = 32'hF000_0000;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
`ifdef IFID_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    ifid_stage_buf #(
        .INSTR_W(32),
        .PC_W   (32),
        .NOP    (NOPW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .instr_out (instr_out),
        .pc_out    (pc_out)
`ifdef IFID_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: in-flight instructions as a FIFO, head is what decode sees.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = '0;
    int unsigned m_cnt = 0;

    always @(posedge clk) begin
        int  n;
        bit  acc;
        ent_t e;
        n = q.size();
        if (rst) begin
            q.delete();
            m_pc  = '0;
            m_cnt = 0;
        end else begin
            if (n == 0 && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && (n < 2);
                if (!stall && n > 0) void'(q.pop_front());
                if (acc) begin
                    e.instr = instr_in;
                    e.pc    = pc_in;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) m_pc = q[0].pc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("m_instr_out", instr_out, (q.size() > 0) ? q[0].instr : NOPW);
            check("m_pc_out", pc_out, m_pc);
            check("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
`ifdef IFID_BUBBLE_CNT_EN
            check("m_bubble_cnt", 32'(bubble_cnt), m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input bit v, input logic [31:0] pc);
        in_valid = v;
        pc_in    = pc;
        instr_in = 32'hA000_0000 + pc;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr_out, 32'hF000_0000);
        check("rst_pc", pc_out, 32'h0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Stream of four, one per cycle
        rst = 1'b0;
        offer(1, 32'h0); tick();
        check("s_first", instr_out, 32'hA000_0000);
        check("s_first_v", 32'(out_valid), 32'd1);
        offer(1, 32'h4); tick();
        offer(1, 32'h8); tick();
        offer(1, 32'hC); tick();
        check("s_last_pc", pc_out, 32'hC);
        check("s_ready", 32'(in_ready), 32'd1);
        offer(0, 32'h0); tick();
        check("bubble_pc_held", pc_out, 32'hC);
        check("bubble_nop", instr_out, 32'hF000_0000);

        // Stall with skid capture
        offer(1, 32'h4); tick();
        stall = 1'b1;
        offer(1, 32'h8); tick();
        check("st_hold", pc_out, 32'h4);
        check("st_ready0", 32'(in_ready), 32'd0);
        offer(1, 32'hC); tick();
        tick();
        check("st_hold3", pc_out, 32'h4);
        stall = 1'b0;
        tick();
        check("drain_pc", pc_out, 32'h8);
        check("drain_ready", 32'(in_ready), 32'd1);
        tick();
        check("after_drain", instr_out, 32'hA000_000C);

        // Flush with both entries full, stall also asserted
        offer(0, 32'h0); tick();
        stall = 1'b1;
        offer(1, 32'h10); tick();
        offer(1, 32'h14); tick();
        check("full_ready0", 32'(in_ready), 32'd0);
        flush = 1'b1;
        offer(1, 32'h18); tick();
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_nop", instr_out, 32'hF000_0000);
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_pc", pc_out, 32'h10);
        flush = 1'b0;
        stall = 1'b0;
        offer(1, 32'h20); tick();
        check("post_fl", pc_out, 32'h20);
        flush = 1'b1;
        offer(1, 32'h24); tick();
        flush = 1'b0;
        offer(0, 32'h0); tick();
        check("fl_discard", pc_out, 32'h20);

        // Reset with two entries held
        stall = 1'b1;
        offer(1, 32'h30); tick();
        offer(1, 32'h34); tick();
        rst = 1'b1;
        tick();
        check("mid_rst_v", 32'(out_valid), 32'd0);
        check("mid_rst_pc", pc_out, 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        rst   = 1'b0;
        stall = 1'b0;
        offer(1, 32'h38); tick();
        check("post_rst", instr_out, 32'hA000_0038);
        offer(0, 32'h0); tick();

`ifdef IFID_BUBBLE_CNT_EN
        // Bubble counter saturation
        rst = 1'b1;
        tick();
        check("cnt_rst", 32'(bubble_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("cnt_one", 32'(bubble_cnt), 32'd1);
        for (int i = 0; i < 19; i++) tick();
        check("cnt_sat", 32'(bubble_cnt), 32'd15);
        rst = 1'b1;
        tick();
        check("cnt_clr", 32'(bubble_cnt), 32'd0);
        rst = 1'b0;
        tick();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
